// File: rtl/frequency_algorithm_mc.sv
// Multi-channel frequency-to-period converter sharing one restoring divider, served round-robin.
// Optional macro FREQ_ALG_ROUND_NEAREST_EN selects round-half-up instead of truncation.
module frequency_algorithm_mc #(
  parameter int CLK_FREQ_KHZ = 100_000,
  parameter int MAX_PERIOD   = 200_000,
  parameter int BIT_WIDTH    = 32,
  parameter int FREQ_WIDTH   = 16,
  parameter int NUM_CH       = 4,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_CH*FREQ_WIDTH-1:0] user_freq,
  output logic [NUM_CH*BIT_WIDTH-1:0]  pulse_period,
  output logic [NUM_CH-1:0]            period_valid,
  output logic [NUM_CH-1:0]            period_err,
  output logic                         busy,
  output logic                         done,
  output logic [CH_W-1:0]              done_ch
);
  localparam int CNT_W = $clog2(BIT_WIDTH) + 1;
  localparam logic [BIT_WIDTH-1:0] DIVIDEND_BASE = BIT_WIDTH'(CLK_FREQ_KHZ * 10);
  localparam logic [BIT_WIDTH-1:0] MAX_P = BIT_WIDTH'(MAX_PERIOD);

  typedef enum logic [1:0] {IDLE, LOAD, DIV, STORE} state_t;
  state_t state, state_n;

  logic [FREQ_WIDTH-1:0] uf        [NUM_CH];
  logic [FREQ_WIDTH-1:0] last_freq [NUM_CH];
  logic [BIT_WIDTH-1:0]  period_q  [NUM_CH];
  logic [NUM_CH-1:0]     pending, mismatch;
  logic [CH_W-1:0]       rr_ptr, cur_ch, winner, next_ptr;
  logic                  any_pend;
  logic [FREQ_WIDTH-1:0] load_freq;
  logic [BIT_WIDTH-1:0]  load_div, load_dividend;
  logic [CNT_W-1:0]      cnt;
  logic                  zero_div;
  logic [BIT_WIDTH-1:0]  divisor_p0, rem_p1, quot_p1;
  logic [BIT_WIDTH:0]    rem_shift, diff, sat_res;

  // {err, period}: zero divisor or over-range quotient clamps to MAX_PERIOD
  function automatic logic [BIT_WIDTH:0] saturate(input logic zero,
                                                  input logic [BIT_WIDTH-1:0] q);
    if (zero || q > MAX_P) return {1'b1, MAX_P};
    return {1'b0, q};
  endfunction

`ifdef FREQ_ALG_ROUND_NEAREST_EN
  function automatic logic [BIT_WIDTH-1:0] round_dividend(input logic [BIT_WIDTH-1:0] d);
    return DIVIDEND_BASE + (d >> 1);
  endfunction
`endif

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      uf[c]       = user_freq[c*FREQ_WIDTH +: FREQ_WIDTH];
      mismatch[c] = (uf[c] != last_freq[c]);
    end
  end

  // Arbiter: lowest pending index overall, overridden by lowest pending at/after rr_ptr
  always_comb begin
    any_pend = |pending;
    winner   = '0;
    for (int c = NUM_CH-1; c >= 0; c--)
      if (pending[c]) winner = CH_W'(c);
    for (int c = NUM_CH-1; c >= 0; c--)
      if (pending[c] && CH_W'(c) >= rr_ptr) winner = CH_W'(c);
    load_freq = '0;
    for (int c = 0; c < NUM_CH; c++)
      if (cur_ch == CH_W'(c)) load_freq = uf[c];
    load_div = BIT_WIDTH'(load_freq);
    next_ptr = (cur_ch == CH_W'(NUM_CH-1)) ? '0 : cur_ch + CH_W'(1);
`ifdef FREQ_ALG_ROUND_NEAREST_EN
    load_dividend = round_dividend(load_div);
`else
    load_dividend = DIVIDEND_BASE;
`endif
    rem_shift = {rem_p1, quot_p1[BIT_WIDTH-1]};
    diff      = rem_shift - {1'b0, divisor_p0};
    sat_res   = saturate(zero_div, quot_p1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    busy    = (state != IDLE);
    case (state)
      IDLE:    if (any_pend) state_n = LOAD;
      LOAD:    state_n = (load_freq == '0) ? STORE : DIV;
      DIV:     if (cnt == CNT_W'(BIT_WIDTH-1)) state_n = STORE;
      STORE:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending      <= '0;
      rr_ptr       <= '0;
      cur_ch       <= '0;
      cnt          <= '0;
      zero_div     <= 1'b0;
      period_valid <= '0;
      period_err   <= '0;
      done         <= 1'b0;
      done_ch      <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        last_freq[c] <= '0;
        period_q[c]  <= '0;
      end
    end else begin
      done <= (state == STORE);
      for (int c = 0; c < NUM_CH; c++) begin
        if (state == LOAD && cur_ch == CH_W'(c)) pending[c] <= 1'b0;
        else if (mismatch[c])                    pending[c] <= 1'b1;
        // A request changed during its own computation keeps valid low until recomputed
        if (mismatch[c])                              period_valid[c] <= 1'b0;
        else if (state == STORE && cur_ch == CH_W'(c)) period_valid[c] <= ~pending[c];
        if (state == STORE && cur_ch == CH_W'(c)) begin
          period_q[c]   <= sat_res[BIT_WIDTH-1:0];
          period_err[c] <= sat_res[BIT_WIDTH];
        end
      end
      case (state)
        IDLE: if (any_pend) cur_ch <= winner;
        LOAD: begin
          last_freq[cur_ch] <= load_freq;
          rr_ptr            <= next_ptr;
          zero_div          <= (load_freq == '0);
          cnt               <= '0;
        end
        DIV:     cnt <= cnt + CNT_W'(1);
        STORE:   done_ch <= cur_ch;
        default: ;
      endcase
    end
  end

  // Divider datapath: LOAD primes, DIV retires one quotient bit per cycle
  always_ff @(posedge clk) begin
    if (state == LOAD) begin
      divisor_p0 <= load_div;
      quot_p1    <= load_dividend;
      rem_p1     <= '0;
    end else if (state == DIV) begin
      rem_p1  <= diff[BIT_WIDTH] ? rem_shift[BIT_WIDTH-1:0] : diff[BIT_WIDTH-1:0];
      quot_p1 <= {quot_p1[BIT_WIDTH-2:0], ~diff[BIT_WIDTH]};
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_pack
    assign pulse_period[c*BIT_WIDTH +: BIT_WIDTH] = period_q[c];
  end

endmodule
